// File: rtl/hash_seq_ctrl.sv
// hash_seq_ctrl: control sequencer for the NTRU-HRSS encapsulation hash path.
// Drives a Keccak-style datapath through PASSES passes. Each pass runs
// LOAD_STEPS absorb-load steps, ROUNDS permutation steps and ANS_STEPS
// accepted squeeze/answer steps. After the last pass the block halts, and it
// restarts from halt on start. A single clock is used throughout: the step
// rate comes from an internal prescaler, and every datapath action is a
// one-cycle strobe qualified by the step tick.
//
// Ports:
//   ex_clk       sole clock, rising edge
//   ovr_rst_n    asynchronous active-low reset
//   start        begin a sequence (sampled only in IDLE or HALT)
//   ans_ready    downstream accepts an answer step
//   busy         high in LOAD, PERMUTE and ANSWER
//   halt_n       low only in HALT
//   phase        prescaler count 0..DIV-1
//   p3_rst       first cycle of each step while busy
//   hash_sp      strobe: first LOAD step of each pass
//   hash_load    strobe: every LOAD step
//   hash_keccak  strobe: every PERMUTE step
//   hash_ans     strobe: every accepted ANSWER step
//   hash_fin     level, high in HALT
//   pass_idx     current pass, 0..PASSES-1
//   done         one-cycle pulse on the first HALT cycle
module hash_seq_ctrl #(
  parameter int unsigned DIV        = 5,
  parameter int unsigned LOAD_STEPS = 5,
  parameter int unsigned ROUNDS     = 24,
  parameter int unsigned ANS_STEPS  = 8,
  parameter int unsigned PASSES     = 3
) (
  input  logic       ex_clk,
  input  logic       ovr_rst_n,
  input  logic       start,
  input  logic       ans_ready,
  output logic       busy,
  output logic       halt_n,
  output logic [3:0] phase,
  output logic       p3_rst,
  output logic       hash_sp,
  output logic       hash_load,
  output logic       hash_keccak,
  output logic       hash_ans,
  output logic       hash_fin,
  output logic [3:0] pass_idx,
  output logic       done
);

  localparam int unsigned PH_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PASS_W = 4;

  // Out-of-range parameters must stop elaboration.
  generate
    if (DIV < 2 || DIV > 16 ||
        LOAD_STEPS < 1 || LOAD_STEPS > 255 ||
        ROUNDS < 1 || ROUNDS > 255 ||
        ANS_STEPS < 1 || ANS_STEPS > 255 ||
        PASSES < 1 || PASSES > 15) begin : g_param_err
      $error("hash_seq_ctrl: parameter out of legal range");
    end
  endgenerate

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_STEPS - 1);
  localparam logic [CNT_W-1:0]  RND_LAST  = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0]  ANS_LAST  = CNT_W'(ANS_STEPS - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PERM = 3'd2;
  localparam logic [2:0] ST_ANS  = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [PH_W-1:0]   phase_q,    phase_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic              done_q,     done_d;

  logic busy_c;
  logic step_tick_c;
  logic ans_acc_c;

  // Decode of the registered state shared by next-state and strobe logic.
  always_comb begin
    busy_c      = (state_q == ST_LOAD) || (state_q == ST_PERM) ||
                  (state_q == ST_ANS);
    step_tick_c = busy_c && (phase_q == PH_LAST);
    ans_acc_c   = (state_q == ST_ANS) && step_tick_c && ans_ready;
  end

  // State and counter registers.
  always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      step_cnt_q <= '0;
      pass_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      step_cnt_q <= step_cnt_d;
      pass_idx_q <= pass_idx_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    step_cnt_d = step_cnt_q;
    pass_idx_d = pass_idx_q;
    done_d     = 1'b0;

    // Prescaler wraps freely while busy, so a refused answer retries one
    // full step later.
    if (busy_c) begin
      phase_d = step_tick_c ? '0 : phase_q + PH_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d    = ST_LOAD;
          phase_d    = '0;
          step_cnt_d = '0;
          pass_idx_d = '0;
        end
      end

      ST_LOAD: begin
        if (step_tick_c) begin
          if (step_cnt_q == LOAD_LAST) begin
            state_d    = ST_PERM;
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PERM: begin
        if (step_tick_c) begin
          if (step_cnt_q == RND_LAST) begin
            state_d    = ST_ANS;
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_ANS: begin
        if (ans_acc_c) begin
          if (step_cnt_q == ANS_LAST) begin
            step_cnt_d = '0;
            if (pass_idx_q == PASS_LAST) begin
              state_d = ST_HALT;
              phase_d = '0;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_LOAD;
              pass_idx_d = pass_idx_q + PASS_W'(1);
            end
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        phase_d    = '0;
        step_cnt_d = '0;
        pass_idx_d = '0;
      end
    endcase
  end

  // Status levels and step-qualified strobes.
  assign busy        = busy_c;
  assign halt_n      = (state_q != ST_HALT);
  assign hash_fin    = (state_q == ST_HALT);
  assign phase       = phase_q;
  assign p3_rst      = busy_c && (phase_q == '0);
  assign hash_sp     = (state_q == ST_LOAD) && step_tick_c && (step_cnt_q == '0);
  assign hash_load   = (state_q == ST_LOAD) && step_tick_c;
  assign hash_keccak = (state_q == ST_PERM) && step_tick_c;
  assign hash_ans    = ans_acc_c;
  assign pass_idx    = pass_idx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_hash_seq_ctrl.sv
// Bench for hash_seq_ctrl: a default-parameter instance and a minimal
// instance (DIV=2, one step of each kind, one pass), both checked every cycle
// against a step-index model, plus literal event-cycle expectations.
module tb_hash_seq_ctrl;

  localparam int AD = 5, AL = 5, AR = 24, AA = 8, AP = 3;
  localparam int BD = 2, BL = 1, BR = 1, BA = 1, BP = 1;

  logic ex_clk = 1'b0;
  logic ovr_rst_n = 1'b0;
  logic start_a = 1'b0, rdy_a = 1'b1;
  logic start_b = 1'b0, rdy_b = 1'b1;

  logic       busy_a, halt_n_a, p3_a, sp_a, load_a, kec_a, ans_a, fin_a, done_a;
  logic [3:0] phase_a, pass_a;
  logic       busy_b, halt_n_b, p3_b, sp_b, load_b, kec_b, ans_b, fin_b, done_b;
  logic [3:0] phase_b, pass_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 ex_clk = ~ex_clk;

  hash_seq_ctrl #(.DIV(AD), .LOAD_STEPS(AL), .ROUNDS(AR), .ANS_STEPS(AA), .PASSES(AP)) u_a (
    .ex_clk(ex_clk), .ovr_rst_n(ovr_rst_n), .start(start_a), .ans_ready(rdy_a),
    .busy(busy_a), .halt_n(halt_n_a), .phase(phase_a), .p3_rst(p3_a),
    .hash_sp(sp_a), .hash_load(load_a), .hash_keccak(kec_a), .hash_ans(ans_a),
    .hash_fin(fin_a), .pass_idx(pass_a), .done(done_a));

  hash_seq_ctrl #(.DIV(BD), .LOAD_STEPS(BL), .ROUNDS(BR), .ANS_STEPS(BA), .PASSES(BP)) u_b (
    .ex_clk(ex_clk), .ovr_rst_n(ovr_rst_n), .start(start_b), .ans_ready(rdy_b),
    .busy(busy_b), .halt_n(halt_n_b), .phase(phase_b), .p3_rst(p3_b),
    .hash_sp(sp_b), .hash_load(load_b), .hash_keccak(kec_b), .hash_ans(ans_b),
    .hash_fin(fin_b), .pass_idx(pass_b), .done(done_b));

  // Model: k is the flat step index within a pass (load, then rounds, then answers).
  typedef struct {
    logic act;
    logic halt;
    logic done;
    int   ph;
    int   k;
    int   pass;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.act = 1'b0; m.halt = 1'b0; m.done = 1'b0;
    m.ph = 0; m.k = 0; m.pass = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, logic st, logic rdy,
                                    int d, int l, int r, int a, int p);
    mdl_t n = m;
    n.done = 1'b0;
    if (!m.act) begin
      if (st) begin
        n.act = 1'b1; n.halt = 1'b0; n.ph = 0; n.k = 0; n.pass = 0;
      end
    end else if (m.ph != d - 1) begin
      n.ph = m.ph + 1;
    end else begin
      n.ph = 0;
      if (m.k < l + r || rdy) begin
        if (m.k == l + r + a - 1) begin
          n.k = 0;
          if (m.pass == p - 1) begin
            n.act = 1'b0; n.halt = 1'b1; n.done = 1'b1;
          end else begin
            n.pass = m.pass + 1;
          end
        end else begin
          n.k = m.k + 1;
        end
      end
    end
    return n;
  endfunction

  // {busy, halt_n, phase, p3_rst, sp, load, keccak, ans, fin, pass_idx, done}
  function automatic logic [16:0] mdl_out(mdl_t m, logic rdy, int d, int l, int r);
    logic tick, sp, ld, kc, an;
    tick = m.act && (m.ph == d - 1);
    sp   = tick && (m.k == 0);
    ld   = tick && (m.k < l);
    kc   = tick && (m.k >= l) && (m.k < l + r);
    an   = tick && (m.k >= l + r) && rdy;
    return {m.act, !m.halt, 4'(m.ph), m.act && (m.ph == 0), sp, ld, kc, an,
            m.halt, 4'(m.pass), m.done};
  endfunction

  // Event log for instance A (cycles relative to t0) and instance B.
  int sp_first, sp_p1, sp_cnt, load_last, load_cnt, kec_first, kec_last, kec_cnt;
  int ans_first, ans_last0, ans_cnt, pass1_first, done_cyc, done_cnt, strb_cnt;
  int b_sp, b_load, b_kec, b_ans, b_done;

  task automatic clear_log();
    sp_first = -1; sp_p1 = -1; sp_cnt = 0; load_last = -1; load_cnt = 0;
    kec_first = -1; kec_last = -1; kec_cnt = 0; ans_first = -1; ans_last0 = -1;
    ans_cnt = 0; pass1_first = -1; done_cyc = -1; done_cnt = 0; strb_cnt = 0;
    b_sp = -1; b_load = -1; b_kec = -1; b_ans = -1; b_done = -1;
  endtask

  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle_();
    logic [16:0] ga, gb, ea, eb;
    int rel;
    @(negedge ex_clk);
    if (!ovr_rst_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end
    rel = cyc - t0;
    ea = mdl_out(ma, rdy_a, AD, AL, AR);
    eb = mdl_out(mb, rdy_b, BD, BL, BR);
    ga = {busy_a, halt_n_a, phase_a, p3_a, sp_a, load_a, kec_a, ans_a, fin_a, pass_a, done_a};
    gb = {busy_b, halt_n_b, phase_b, p3_b, sp_b, load_b, kec_b, ans_b, fin_b, pass_b, done_b};
    n_cmp++;
    if (ga !== ea) begin
      n_bad++;
      $display("FAIL outputs_a cyc=%0d rel=%0d got=%h exp=%h", cyc, rel, ga, ea);
    end
    n_cmp++;
    if (gb !== eb) begin
      n_bad++;
      $display("FAIL outputs_b cyc=%0d rel=%0d got=%h exp=%h", cyc, rel, gb, eb);
    end
    if (sp_a) begin
      sp_cnt++;
      if (pass_a == 4'd0 && sp_first < 0) sp_first = rel;
      if (pass_a == 4'd1 && sp_p1 < 0) sp_p1 = rel;
    end
    if (load_a && pass_a == 4'd0) begin load_last = rel; load_cnt++; end
    if (kec_a && pass_a == 4'd0) begin
      if (kec_first < 0) kec_first = rel;
      kec_last = rel; kec_cnt++;
    end
    if (ans_a) begin
      ans_cnt++;
      if (ans_first < 0) ans_first = rel;
      if (pass_a == 4'd0) ans_last0 = rel;
    end
    if (pass_a == 4'd1 && pass1_first < 0) pass1_first = rel;
    if (done_a) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = rel;
    end
    if (sp_a || load_a || kec_a || ans_a || sp_b || load_b || kec_b || ans_b) strb_cnt++;
    if (sp_b && b_sp < 0) b_sp = rel;
    if (load_b && b_load < 0) b_load = rel;
    if (kec_b && b_kec < 0) b_kec = rel;
    if (ans_b && b_ans < 0) b_ans = rel;
    if (done_b && b_done < 0) b_done = rel;
    @(posedge ex_clk);
    if (ovr_rst_n) begin
      ma = mdl_next(ma, start_a, rdy_a, AD, AL, AR, AA, AP);
      mb = mdl_next(mb, start_b, rdy_b, BD, BL, BR, BA, BP);
    end
    cyc++;
    #1;
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    clear_log();

    // Power-on reset, then a few idle cycles.
    for (int i = 0; i < 3; i++) cycle_();
    ovr_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle_();

    // Run 1: single start pulse on both instances, ans_ready held high.
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 562; i++) begin
      start_a = (i == 0);
      start_b = (i == 0);
      cycle_();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk("run1_sp_first", sp_first, 5);
    chk("run1_load_last", load_last, 25);
    chk("run1_load_cnt", load_cnt, 5);
    chk("run1_kec_first", kec_first, 30);
    chk("run1_kec_last", kec_last, 145);
    chk("run1_kec_cnt", kec_cnt, 24);
    chk("run1_ans_first", ans_first, 150);
    chk("run1_ans_last0", ans_last0, 185);
    chk("run1_pass1_first", pass1_first, 186);
    chk("run1_sp_pass1", sp_p1, 190);
    chk("run1_sp_cnt", sp_cnt, 3);
    chk("run1_ans_cnt", ans_cnt, 24);
    chk("run1_done_cyc", done_cyc, 556);
    chk("run1_done_cnt", done_cnt, 1);
    chk("b_sp", b_sp, 2);
    chk("b_load", b_load, 2);
    chk("b_kec", b_kec, 4);
    chk("b_ans", b_ans, 6);
    chk("b_done", b_done, 7);

    // Run 2: restart from HALT with start held 3 cycles; first two answer
    // ticks of pass 0 refused.
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 575; i++) begin
      start_a = (i <= 2);
      rdy_a   = !(i >= 140 && i <= 155);
      cycle_();
    end
    start_a = 1'b0;
    rdy_a   = 1'b1;
    chk("run2_sp_first", sp_first, 5);
    chk("run2_sp_cnt", sp_cnt, 3);
    chk("run2_ans_first", ans_first, 160);
    chk("run2_ans_last0", ans_last0, 195);
    chk("run2_ans_cnt", ans_cnt, 24);
    chk("run2_done_cyc", done_cyc, 566);
    chk("run2_done_cnt", done_cnt, 1);

    // Run 3: reset asserted mid-PERMUTE, then idle with start low.
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      start_a = (i == 0);
      cycle_();
    end
    start_a = 1'b0;
    chk("run3_kec_before_rst", kec_cnt, 14);
    strb_cnt = 0;
    ovr_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) cycle_();
    ovr_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) cycle_();
    chk("run3_strobes_after_rst", strb_cnt, 0);
    chk("run3_busy_after_rst", int'(busy_a), 0);
    chk("run3_halt_n_after_rst", int'(halt_n_a), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
